fpu_div_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one combinational 64-bit IEEE-754 divide unit among N_REQ requesters.
- Registers the winning operands and holds them stable on the divider inputs for DIV_LAT cycles, so the divider runs as a multicycle path.
- Captures the quotient and returns it on a valid/ready response channel tagged with the requester index.
- One operation in flight at a time.

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fpu_div_arb_rr_arbiter.sv | 43 ++++
 rtl/fpu_div_arb.sv | 150 +++++++++++++++
 tb/tb_fpu_div_arb.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the divide-unit arbiter:
//   - fpu_state_e : sequencer state encoding (ST_IDLE, ST_WAIT, ST_RESP)
//   - FP64_*      : IEEE-754 binary64 field widths and the +infinity pattern
// No ports (package).
// -----------------------------------------------------------------------------
package fpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fpu_state_e;

  localparam int FP64_W      = 64;
  localparam int FP64_EXP_W  = 11;
  localparam int FP64_FRAC_W = 52;

  localparam logic [FP64_W-1:0] FP64_POS_INF = 64'h7FF0000000000000;

endpackage

// File: rtl/fpu_div_arb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches the valid vector starting one
// position above the pointer (wrapping modulo N) and returns the first hit.
// Ports:
//   valid_i [N-1:0]     request vector
//   ptr_i   [IDX_W-1:0] index of the most recent winner
//   grant_o [N-1:0]     one-hot winner (all zero when nothing is valid)
//   idx_o   [IDX_W-1:0] encoded winner index (0 when nothing is valid)
//   any_o               at least one request is valid
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    int  cand;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    // k runs 1..N so the current pointer holder is considered last.
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!found && valid_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDX_W'(cand);
      end
    end
  end

  assign any_o = |valid_i;

endmodule

// File: rtl/fpu_div_arb.sv
// -----------------------------------------------------------------------------
// fpu_div_arb
// Shares one combinational binary64 divide unit among N_REQ requesters.
// A round-robin winner's operands are registered onto div_a/div_b and held
// for DIV_LAT cycles (multicycle path through the divider), then the quotient
// is captured and offered on a valid/ready response channel with the
// requester tag. Only one operation is in flight at a time.
//
// Optional build macro: FPU_DIV_ARB_FLAGS_EN
//   defined   : rsp_flags = {div_by_zero, zero_dividend} from latched operands
//   undefined : rsp_flags tied to 2'b00
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester request, one-hot acceptance (IDLE only)
//   req_a/req_b             operand slices, slice i = [64*i+63:64*i]
//   div_a/div_b/div_result  divide unit interface
//   rsp_valid/rsp_ready     response handshake
//   rsp_data/rsp_id/rsp_flags  captured quotient, requester tag, flags
//   busy                    sequencer not in IDLE
// -----------------------------------------------------------------------------
module fpu_div_arb
  import fpu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DIV_LAT = 3,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [FP64_W*N_REQ-1:0] req_a,
  input  logic [FP64_W*N_REQ-1:0] req_b,
  output logic [FP64_W-1:0]       div_a,
  output logic [FP64_W-1:0]       div_b,
  input  logic [FP64_W-1:0]       div_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [FP64_W-1:0]       rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic [1:0]              rsp_flags,
  output logic                    busy
);

  // Counter only needs to hold DIV_LAT-1.
  localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  fpu_state_e         state_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    id_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [FP64_W-1:0]  div_a_q;
  logic [FP64_W-1:0]  div_b_q;
  logic [FP64_W-1:0]  rsp_data_q;
  logic [ID_W-1:0]    rsp_id_q;

  logic [N_REQ-1:0]   grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_rr_arbiter (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

`ifdef FPU_DIV_ARB_FLAGS_EN
  logic [1:0] rsp_flags_q;
  logic [1:0] flags_d;
  logic       div_by_zero;
  logic       zero_dividend;

  // Magnitude bits only: signed zeros count as zero.
  always_comb begin
    div_by_zero   = (div_b_q[FP64_EXP_W+FP64_FRAC_W-1:0] == '0);
    zero_dividend = (div_a_q[FP64_EXP_W+FP64_FRAC_W-1:0] == '0) && !div_by_zero;
    flags_d       = {div_by_zero, zero_dividend};
  end

  assign rsp_flags = rsp_flags_q;
`else
  assign rsp_flags = 2'b00;
`endif

  // Gated by rst_n so the strobe is quiet while reset is held, even though
  // the state register already reads IDLE.
  assign req_ready = (rst_n && (state_q == ST_IDLE)) ? grant : '0;
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= ID_W'(N_REQ-1);
      id_q        <= '0;
      cnt_q       <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
`ifdef FPU_DIV_ARB_FLAGS_EN
      rsp_flags_q <= 2'b00;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            div_a_q  <= req_a[FP64_W*grant_idx +: FP64_W];
            div_b_q  <= req_b[FP64_W*grant_idx +: FP64_W];
            id_q     <= grant_idx;
            rr_ptr_q <= grant_idx;
            cnt_q    <= CNT_W'(DIV_LAT-1);
            state_q  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Operands have been stable for DIV_LAT cycles when cnt reaches 0.
          if (cnt_q == '0) begin
            rsp_data_q  <= div_result;
            rsp_id_q    <= id_q;
`ifdef FPU_DIV_ARB_FLAGS_EN
            rsp_flags_q <= flags_d;
`endif
            state_q     <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          // Return to IDLE; arbitration resumes on the following cycle.
          if (rsp_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_div_arb.sv
module tb_fpu_div_arb;
  import fpu_pkg::*;

  localparam int N_REQ   = 4;
  localparam int DIV_LAT = 3;
  localparam int ID_W    = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [64*N_REQ-1:0]     req_a;
  logic [64*N_REQ-1:0]     req_b;
  logic [63:0]             div_a;
  logic [63:0]             div_b;
  logic [63:0]             div_result;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [63:0]             rsp_data;
  logic [ID_W-1:0]         rsp_id;
  logic [1:0]              rsp_flags;
  logic                    busy;

  always #5 clk = ~clk;

  fpu_div_arb #(
    .N_REQ   (N_REQ),
    .DIV_LAT (DIV_LAT),
    .ID_W    (ID_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_result (div_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_flags  (rsp_flags),
    .busy       (busy)
  );

  // Behavioural divide unit sitting beside the arbiter.
  function automatic logic [63:0] fdiv(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) / $bitstoreal(b));
  endfunction

  function automatic logic [1:0] flags_of(input logic [63:0] a, input logic [63:0] b);
`ifdef FPU_DIV_ARB_FLAGS_EN
    logic dbz;
    dbz = (b[62:0] == 63'd0);
    return {dbz, (a[62:0] == 63'd0) && !dbz};
`else
    return 2'b00;
`endif
  endfunction

  always_comb div_result = fdiv(div_a, div_b);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [63:0]     data;
    logic [1:0]      flags;
  } exp_t;

  exp_t sb[$];
  int   grant_ids[$];
  int   grant_cyc[$];

  int checks   = 0;
  int errors   = 0;
  int n_grants = 0;
  int n_rsps   = 0;
  int cyc      = 0;

  logic [63:0]     last_data;
  logic [ID_W-1:0] last_id;
  logic [1:0]      last_flags;
  int              last_rsp_cyc;

  exp_t mon_e;
  int   mon_g;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: push expectations on grants, pop and compare on response handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ready != '0) begin
        mon_g = 0;
        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) mon_g = i;
        check("ready_onehot", 64'($onehot(req_ready)), 64'd1);
        check("ready_is_valid", 64'((req_ready & req_valid) != '0), 64'd1);
        check("ready_not_busy", 64'(busy), 64'd0);
        sb.push_back({ID_W'(mon_g),
                      fdiv(req_a[64*mon_g +: 64], req_b[64*mon_g +: 64]),
                      flags_of(req_a[64*mon_g +: 64], req_b[64*mon_g +: 64])});
        grant_ids.push_back(mon_g);
        grant_cyc.push_back(cyc);
        n_grants++;
      end
      if (busy) check("ready_while_busy", 64'(req_ready), 64'd0);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_data", rsp_data, mon_e.data);
          check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
          check("rsp_flags", 64'(rsp_flags), 64'(mon_e.flags));
        end
        last_data    = rsp_data;
        last_id      = rsp_id;
        last_flags   = rsp_flags;
        last_rsp_cyc = cyc;
        n_rsps++;
        $display("rsp cyc=%0d id=%0d data=%h flags=%b", cyc, rsp_id, rsp_data, rsp_flags);
      end
    end
  end

  task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b);
    req_a[64*i +: 64] = a;
    req_b[64*i +: 64] = b;
  endtask

  task automatic wait_grants(input int target);
    int k;
    k = 0;
    while (n_grants < target && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (n_grants < target) check("grant_timeout", 64'(n_grants), 64'(target));
    #1;
  endtask

  task automatic wait_rsps(input int target);
    int k;
    k = 0;
    while (n_rsps < target && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (n_rsps < target) check("rsp_timeout", 64'(n_rsps), 64'(target));
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_div_a"},     div_a, 64'd0);
    check({tag, "_div_b"},     div_b, 64'd0);
    check({tag, "_rsp_data"},  rsp_data, 64'd0);
    check({tag, "_rsp_id"},    64'(rsp_id), 64'd0);
    check({tag, "_rsp_flags"}, 64'(rsp_flags), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_busy"},      64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int r0;
    int k;
    logic [63:0] hold;

    rst_n     = 1'b0;
    req_valid = '1;     // requests present during reset must not be acknowledged
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single op: 6.0 / 2.0 from requester 0.
    set_op(0, 64'h4018000000000000, 64'h4000000000000000);
    rsp_ready = 1'b1;
    g0 = n_grants; r0 = n_rsps;
    req_valid = 4'b0001;
    wait_grants(g0 + 1);
    req_valid = '0;
    check("single_grant_id", 64'(grant_ids[g0]), 64'd0);
    @(negedge clk); #1;
    check("single_ready_pulse", 64'(req_ready), 64'd0);
    wait_rsps(r0 + 1);
    check("single_data", last_data, 64'h4008000000000000);
    check("single_id", 64'(last_id), 64'd0);
    check("single_latency", 64'(last_rsp_cyc - grant_cyc[g0]), 64'(DIV_LAT + 1));

    // Backpressure: requester 1 (9.0/3.0) held in RESP while requester 2 waits.
    set_op(1, 64'h4022000000000000, 64'h4008000000000000);
    set_op(2, 64'h0000000000000000, 64'h4000000000000000);
    rsp_ready = 1'b0;
    g0 = n_grants; r0 = n_rsps;
    req_valid = 4'b0010;
    wait_grants(g0 + 1);
    req_valid = 4'b0100;
    k = 0;
    @(negedge clk);
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("bp_rsp_seen", 64'(rsp_valid), 64'd1);
    hold = rsp_data;
    check("bp_data", hold, 64'h4008000000000000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_hold", 64'(rsp_valid), 64'd1);
      check("bp_data_hold", rsp_data, hold);
      check("bp_no_ready", 64'(req_ready), 64'd0);
      check("bp_busy", 64'(busy), 64'd1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    check("bp_idle_busy", 64'(busy), 64'd0);
    check("bp_idle_rsp_valid", 64'(rsp_valid), 64'd0);
    check("bp_next_grant", 64'(req_ready), 64'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsps(r0 + 2);
    check("zero_div_data", last_data, 64'd0);
    check("zero_div_id", 64'(last_id), 64'd2);
`ifdef FPU_DIV_ARB_FLAGS_EN
    check("zero_div_flags", 64'(last_flags), 64'b01);
`else
    check("zero_div_flags", 64'(last_flags), 64'b00);
`endif

    // Divide by zero from requester 3.
    set_op(3, 64'h3FF0000000000000, 64'h0000000000000000);
    g0 = n_grants; r0 = n_rsps;
    req_valid = 4'b1000;
    wait_grants(g0 + 1);
    req_valid = '0;
    wait_rsps(r0 + 1);
    check("dbz_data", last_data, FP64_POS_INF);
    check("dbz_id", 64'(last_id), 64'd3);
`ifdef FPU_DIV_ARB_FLAGS_EN
    check("dbz_flags", 64'(last_flags), 64'b10);
`else
    check("dbz_flags", 64'(last_flags), 64'b00);
`endif

    // Fairness: all requesters active, pointer currently at 3.
    for (int i = 0; i < N_REQ; i++)
      set_op(i, $realtobits(real'(i + 1) * 10.0), $realtobits(real'(i + 2)));
    g0 = n_grants;
    req_valid = '1;
    wait_grants(g0 + 6);
    req_valid = '0;
    wait_rsps(n_grants);
    for (int j = 0; j < 6; j++) begin
      if (g0 + j < grant_ids.size())
        check("fair_order", 64'(grant_ids[g0 + j]), 64'(j % N_REQ));
      if (j > 0 && g0 + j < grant_cyc.size())
        check("fair_spacing", 64'(grant_cyc[g0 + j] - grant_cyc[g0 + j - 1]), 64'(DIV_LAT + 2));
    end

    // Reset in the first WAIT cycle abandons the operation.
    set_op(0, 64'h4018000000000000, 64'h4000000000000000);
    g0 = n_grants;
    req_valid = 4'b0001;
    wait_grants(g0 + 1);
    check("mid_reset_busy_before", 64'(busy), 64'd1);
    rst_n     = 1'b0;
    req_valid = 4'b1010;
    #1;
    check_reset_outputs("mid_reset");
    sb.delete();
    r0 = n_rsps;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("post_reset_grant", 64'(req_ready), 64'b0010);
    check("post_reset_no_rsp", 64'(n_rsps), 64'(r0));
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsps(r0 + 1);
    check("post_reset_rsp_id", 64'(last_id), 64'd1);
    check("post_reset_rsp_data", last_data, fdiv(req_a[64 +: 64], req_b[64 +: 64]));
    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
